// File: rtl/board_vga_renderer_if.sv
// Bus between the game-state block and the VGA renderer: pixel tick and
// game-state snapshot inputs towards the renderer, VGA pin outputs back.
interface board_vga_renderer_if;
  logic         pix_en;
  logic [199:0] cell_status_flat;
  logic [4:0]   turns_left;
  logic [3:0]   sprite_row;
  logic [3:0]   sprite_col;
  logic         hsync;
  logic         vsync;
  logic [11:0]  rgb;
  logic         frame_start;

  modport master (
    output pix_en, cell_status_flat, turns_left, sprite_row, sprite_col,
    input  hsync, vsync, rgb, frame_start
  );

  modport slave (
    input  pix_en, cell_status_flat, turns_left, sprite_row, sprite_col,
    output hsync, vsync, rgb, frame_start
  );
endinterface

// File: rtl/board_vga_renderer.sv
// VGA timing plus a two-stage pixel pipeline drawing the 10x10 board, cursor,
// turns bar and game-over border from a once-per-frame shadow of the game state.
module board_vga_renderer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int GRID_X0  = 120,
  parameter int GRID_Y0  = 40,
  parameter int CELL     = 40,
  parameter int BAR_GAP  = 10,
  parameter int BAR_H    = 10,
  parameter int BAR_UNIT = 16
) (
  input  logic clk,
  input  logic reset,
  board_vga_renderer_if.slave bus
);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] GX0      = 10'(GRID_X0);
  localparam logic [9:0] GX1      = 10'(GRID_X0 + 10 * CELL);
  localparam logic [9:0] GY0      = 10'(GRID_Y0);
  localparam logic [9:0] GY1      = 10'(GRID_Y0 + 10 * CELL);
  localparam logic [9:0] BY0      = 10'(GRID_Y0 + 10 * CELL + BAR_GAP);
  localparam logic [9:0] BY1      = 10'(GRID_Y0 + 10 * CELL + BAR_GAP + BAR_H);
  localparam logic [9:0] BAR_W    = 10'(BAR_UNIT);
  localparam logic [5:0] OFF_LAST = 6'(CELL - 1);
  localparam logic [5:0] EDGE_LO  = 6'd3;
  localparam logic [5:0] EDGE_HI  = 6'(CELL - 3);

  logic [9:0]   hc, vc, hc_next, vc_next, bar_end;
  logic [5:0]   offx, offy;
  logic [3:0]   col, row;
  logic [199:0] sh_board;
  logic [4:0]   sh_turns;
  logic [3:0]   sh_row, sh_col;
  logic [1:0]   cells [100];
  logic [6:0]   cell_idx;
  logic [1:0]   cell_now;
  logic         frame_end, in_grid, in_bar, in_band, cursor_hit;

  logic         p1_hsync, p1_vsync, p1_active, p1_grid, p1_cursor, p1_line, p1_bar, p1_over;
  logic [1:0]   p1_status;
  logic         hsync_reg, vsync_reg, frame_start_reg;
  logic [11:0]  rgb_reg;

  for (genvar gi = 0; gi < 100; gi++) begin : g_cells
    assign cells[gi] = sh_board[gi*2 +: 2];
  end

  assign hc_next    = (hc == H_LAST) ? '0 : hc + 10'd1;
  assign vc_next    = (vc == V_LAST) ? '0 : vc + 10'd1;
  assign frame_end  = (hc == H_LAST) && (vc == V_LAST);
  assign in_grid    = (hc >= GX0) && (hc < GX1) && (vc >= GY0) && (vc < GY1);
  assign bar_end    = GX0 + {5'd0, sh_turns} * BAR_W;
  assign in_bar     = (vc >= BY0) && (vc < BY1) && (hc >= GX0) && (hc < bar_end);
  assign in_band    = (offx < EDGE_LO) || (offx >= EDGE_HI) || (offy < EDGE_LO) || (offy >= EDGE_HI);
  assign cursor_hit = (row == sh_row) && (col == sh_col) && in_band;
  assign cell_idx   = {3'd0, row} * 7'd10 + {3'd0, col};
  assign cell_now   = (cell_idx < 7'd100) ? cells[cell_idx] : 2'b00;

  // offx/offy and col/row track (hc-GX0)%CELL etc.; they restart on entering the grid.
  always_ff @(posedge clk) begin
    if (reset) begin
      hc   <= '0;
      vc   <= '0;
      offx <= '0;
      offy <= '0;
      col  <= '0;
      row  <= '0;
    end else if (bus.pix_en) begin
      hc <= hc_next;
      if (hc_next == GX0) begin
        offx <= '0;
        col  <= '0;
      end else if (offx == OFF_LAST) begin
        offx <= '0;
        col  <= col + 4'd1;
      end else begin
        offx <= offx + 6'd1;
      end
      if (hc == H_LAST) begin
        vc <= vc_next;
        if (vc_next == GY0) begin
          offy <= '0;
          row  <= '0;
        end else if (offy == OFF_LAST) begin
          offy <= '0;
          row  <= row + 4'd1;
        end else begin
          offy <= offy + 6'd1;
        end
      end
    end
  end

  // Snapshot on the last pixel of the frame so the whole next frame uses one state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_board        <= '0;
      sh_turns        <= 5'd15;
      sh_row          <= '0;
      sh_col          <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= bus.pix_en && frame_end;
      if (bus.pix_en && frame_end) begin
        sh_board <= bus.cell_status_flat;
        sh_turns <= bus.turns_left;
        sh_row   <= bus.sprite_row;
        sh_col   <= bus.sprite_col;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p1_hsync  <= 1'b1;
      p1_vsync  <= 1'b1;
      p1_active <= 1'b0;
      p1_grid   <= 1'b0;
      p1_cursor <= 1'b0;
      p1_line   <= 1'b0;
      p1_bar    <= 1'b0;
      p1_over   <= 1'b0;
      p1_status <= 2'b00;
      hsync_reg <= 1'b1;
      vsync_reg <= 1'b1;
      rgb_reg   <= '0;
    end else if (bus.pix_en) begin
      p1_hsync  <= !((hc >= HS_BEG) && (hc < HS_END));
      p1_vsync  <= !((vc >= VS_BEG) && (vc < VS_END));
      p1_active <= (hc < H_ACT) && (vc < V_ACT);
      p1_grid   <= in_grid;
      p1_cursor <= cursor_hit;
      p1_line   <= (offx == 6'd0) || (offy == 6'd0);
      p1_bar    <= in_bar;
      p1_over   <= (sh_turns == 5'd0);
      p1_status <= cell_now;
      hsync_reg <= p1_hsync;
      vsync_reg <= p1_vsync;
      if (!p1_active)     rgb_reg <= 12'h000;
      else if (p1_grid) begin
        if (p1_cursor)    rgb_reg <= 12'hFF0;
        else if (p1_line) rgb_reg <= 12'hFFF;
        else begin
          case (p1_status)
            2'b00:   rgb_reg <= 12'h00F;
            2'b01:   rgb_reg <= 12'h888;
            2'b10:   rgb_reg <= 12'h000;
            default: rgb_reg <= 12'hF00;
          endcase
        end
      end
      else if (p1_bar)    rgb_reg <= 12'h0F0;
      else if (p1_over)   rgb_reg <= 12'h400;
      else                rgb_reg <= 12'h111;
    end
  end

  assign bus.hsync       = hsync_reg;
  assign bus.vsync       = vsync_reg;
  assign bus.rgb         = rgb_reg;
  assign bus.frame_start = frame_start_reg;
endmodule
